// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: stimulus transmitter for a/b/d handshake frames.
//
// A start request launches a burst of `reps` frames (a ##1 b ##1 d), each separated by `gap`
// idle cycles. `mode` selects a complete frame or one of three deliberately broken variants.
// All outputs are registered and decoded from the next state, so they line up with the state
// register.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      launch a burst (sampled only while idle)
//   abort      synchronous abort of the current burst
//   mode       0 complete, 1 drop d, 2 drop b, 3 a/b overlap
//   gap        idle cycles between consecutive frames
//   reps       frames per burst (0 treated as 1)
//   a_out      frame start strobe
//   b_out      second-beat strobe
//   d_out      frame completion strobe
//   busy       burst in progress
//   done       one-cycle pulse after the final frame
//   frame_cnt  frames completed in the current burst
module seq_pattern_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] reps,
  output logic             a_out,
  output logic             b_out,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {StIdle, StA, StB, StD, StGap} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] frame_cnt_d;
  logic [CNT_W-1:0] frames_next;
  logic             a_d, b_d, d_d, busy_d, done_d;

  assign frames_next = frame_cnt + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    gap_d       = gap_q;
    reps_d      = reps_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt;
    done_d      = 1'b0;

    if (state_q != StIdle && abort) begin
      // Abort wins over every other transition; frame_cnt keeps its value.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d     = StA;
            mode_d      = mode;
            gap_d       = gap;
            reps_d      = (reps == '0) ? CNT_W'(1) : reps;
            frame_cnt_d = '0;
          end
        end
        StA: state_d = StB;
        StB: state_d = StD;
        StD: begin
          frame_cnt_d = frames_next;
          if (frames_next == reps_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = StGap;
            gap_cnt_d = gap_q;
          end else begin
            state_d = StA;
          end
        end
        StGap: begin
          // Loaded with gap on entry; the cycle that sees 1 is the last idle cycle.
          if (gap_cnt_q <= CNT_W'(1)) begin
            state_d = StA;
          end else begin
            gap_cnt_d = gap_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Strobes decoded from the next state; mode_d already holds the freshly latched mode
  // on the cycle a burst is accepted.
  always_comb begin
    a_d    = (state_d == StA);
    b_d    = ((state_d == StA) && (mode_d == 2'd3)) || ((state_d == StB) && !mode_d[1]);
    d_d    = (state_d == StD) && (mode_d != 2'd1);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= 2'd0;
      gap_q     <= '0;
      reps_q    <= '0;
      gap_cnt_q <= '0;
      frame_cnt <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      d_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      reps_q    <= reps_d;
      gap_cnt_q <= gap_cnt_d;
      frame_cnt <= frame_cnt_d;
      a_out     <= a_d;
      b_out     <= b_d;
      d_out     <= d_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Single-clock stimulus transmitter that drives the a/b/d handshake frames consumed by the end-point/matched sequence checker blocks.
- On a start request it emits N frames of the form a ##1 b ##1 d, separated by programmable idle gaps.
- Selectable fault modes produce deliberately broken frames, so checker covers and assertions are exercised on both pass and fail paths.
- Sits in the bench-side stimulus layer, driving the checker's a/b/d inputs directly.

Parameters:
- CNT_W, 8, width of the gap, repeat and frame counters.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to launch a burst; sampled only while busy=0.
- abort  input  1  synchronous abort of the current burst.
- mode  input  2  frame type: 0 complete, 1 drop d, 2 drop b, 3 a/b overlap.
- gap  input  CNT_W  idle cycles inserted between consecutive frames.
- reps  input  CNT_W  number of frames in the burst; 0 is treated as 1.
- a_out  output  1  frame start strobe.
- b_out  output  1  second-beat strobe.
- d_out  output  1  frame completion strobe.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse after the final frame of a burst.
- frame_cnt  output  CNT_W  frames completed in the current burst.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - a_out, b_out, d_out, busy, done = 0; frame_cnt = 0.
  - Takes effect immediately, even mid-frame; outputs go low without waiting for a clock edge.
- All outputs are registered, decoded from the next state so they are aligned with the state register.
- FSM states: IDLE, SA, SB, SD, GAP.
- IDLE:
  - If start=1, latch mode, gap, and reps (reps=0 becomes 1).
  - Clear frame_cnt and go to SA. busy=1 from the SA cycle.
  - start while busy=1 is ignored; the latched values do not change.
- SA: a_out=1. In mode 3, b_out=1 as well. Next state SB.
- SB: b_out=1 in modes 0 and 1; b_out=0 in modes 2 and 3. a_out=0. Next state SD.
- SD:
  - d_out=1 in modes 0, 2 and 3; d_out=0 in mode 1.
  - frame_cnt increments on leaving SD, wrapping modulo 2^CNT_W.
  - If the frames completed now equal the latched reps, go to IDLE: done=1 for that single IDLE cycle, busy=0.
  - Otherwise go to GAP if the latched gap is nonzero, or straight to SA if gap=0 (back-to-back frames, with no idle cycle between d and the next a).
- GAP:
  - All strobes are 0.
  - A down-counter loaded with the gap value runs for exactly gap cycles, then the FSM goes to SA.
- Frame latency: start sampled at edge k gives a_out high in cycle k+1, b_out in k+2 and d_out in k+3 (mode 0).
- Burst length in clock cycles: 3*reps + gap*(reps-1).
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with all strobes 0 and busy=0.
  - done stays 0; frame_cnt holds its last value.
  - abort takes priority over every other transition.
  - abort in IDLE has no effect; abort and start together in IDLE means start is ignored.
- start in the same cycle that done is high (IDLE) is accepted, which launches a new burst with no gap.
- At most one of a_out, d_out is high in any cycle. a_out and b_out are high together only in mode 3.

Test Plan:
- Complete frames: mode=0, reps=1, gap=0, start at cycle 10 -> a=1 @11, b=1 @12, d=1 @13; done=1 @14; frame_cnt=1; busy high cycles 11-13.
- Repeated frames with gaps: mode=0, reps=3, gap=2 -> a pulses @ cycles 1, 6, 11 relative to start; d pulses @ 3, 8, 13; done @14; frame_cnt=3. Repeat with gap=0 -> a @1,4,7; d @3,6,9; done @10.
- Fault modes with reps=1:
  - mode=1 -> d never asserted, done still pulses.
  - mode=2 -> b stays low during SB.
  - mode=3 -> a and b both 1 in the SA cycle only.
- Abort: mode=0, reps=4, gap=1, abort pulsed in the SB cycle of frame 2 -> all strobes 0 next cycle, busy=0, done never pulses, frame_cnt=1. A new start afterwards behaves as a fresh burst, with frame_cnt reset to 0.
- Reset mid-frame: rst_n driven low asynchronously in the middle of the SD cycle -> d_out and busy fall before the next clock edge. After release, IDLE holds with all outputs 0 until start.
- Edge cases:
  - reps=0 -> exactly one frame.
  - start held high for the whole burst -> a second burst starts in the done cycle's successor, with a @ done+1.
  - reps=255, CNT_W=8 -> frame_cnt reaches 255 and done pulses once.
